axi_rd_arbiter: RTL and testbench

- Round-robin arbiter sharing the single AXI4 read port of the SDRAM stub between NUM_REQ read requesters.
- Typical requesters: voxel grid fetch and framebuffer scanout.
- One burst outstanding at a time. The AR request is registered; R beats are routed combinationally back to the granted requester.
- Sits between the requester read masters and axi_sdram_stub's AR/R channels.

---
 rtl/axi_arb_pkg.sv | 14 +
 rtl/rr_grant.sv | 41 ++++
 rtl/axi_rd_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared state encoding and AXI constants for the SDRAM read-port arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } arb_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam logic [1:0] RESP_SLVERR    = 2'b10;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
module rr_grant #(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rrPtr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grantIdx,
    output logic               o_anyReq
);

    logic [NUM_REQ-1:0] w_reqRot;
    logic [IDX_W:0]     w_sum;
    logic               w_found;

    // Rotating the request vector puts the pointer position at bit 0, so a plain priority scan suffices.
    assign w_reqRot = NUM_REQ'({i_req, i_req} >> i_rrPtr);
    assign o_anyReq = |i_req;

    always_comb begin
        w_found    = 1'b0;
        w_sum      = '0;
        o_grantIdx = '0;
        o_grant    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_reqRot[i]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, i_rrPtr} + (IDX_W+1)'(i);
                if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                    w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
                end
                o_grantIdx = w_sum[IDX_W-1:0];
            end
        end
        if (w_found) begin
            o_grant = NUM_REQ'(1) << o_grantIdx;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port among NUM_REQ masters.
// One burst in flight; AR is registered, R beats are routed combinationally to the granted master.
module axi_rd_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*ID_WIDTH-1:0]   s_arid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_araddr,
    input  logic [NUM_REQ*8-1:0]          s_arlen,
    input  logic [NUM_REQ*3-1:0]          s_arsize,
    input  logic [NUM_REQ*2-1:0]          s_arburst,
    input  logic [NUM_REQ-1:0]            s_arvalid,
    output logic [NUM_REQ-1:0]            s_arready,
    output logic [ID_WIDTH-1:0]           s_rid,
    output logic [DATA_WIDTH-1:0]         s_rdata,
    output logic [1:0]                    s_rresp,
    output logic                          s_rlast,
    output logic [NUM_REQ-1:0]            s_rvalid,
    input  logic [NUM_REQ-1:0]            s_rready,
    output logic [ID_WIDTH-1:0]           m_axi_arid,
    output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [ID_WIDTH-1:0]           m_axi_rid,
    input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_idx,
    output logic                          busy,
    output logic                          id_err,
    output logic [31:0]                   beat_count
);

    import axi_arb_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e            r_state;
    arb_state_e            w_nextState;
    logic [IDX_W-1:0]      r_rrPtr;
    logic [IDX_W-1:0]      r_grantIdx;
    logic [ID_WIDTH-1:0]   r_arId;
    logic [ADDR_WIDTH-1:0] r_arAddr;
    logic [7:0]            r_arLen;
    logic [2:0]            r_arSize;
    logic [1:0]            r_arBurst;
    logic                  r_idErr;
    logic [31:0]           r_beatCount;

    logic [ID_WIDTH-1:0]   w_arId    [NUM_REQ];
    logic [ADDR_WIDTH-1:0] w_arAddr  [NUM_REQ];
    logic [7:0]            w_arLen   [NUM_REQ];
    logic [2:0]            w_arSize  [NUM_REQ];
    logic [1:0]            w_arBurst [NUM_REQ];

    logic [NUM_REQ-1:0]    w_grant;
    logic [IDX_W-1:0]      w_winIdx;
    logic                  w_anyReq;
    logic                  w_take;
    logic                  w_rreadySel;
    logic                  w_beat;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_arId[i]    = s_arid[i*ID_WIDTH +: ID_WIDTH];
            w_arAddr[i]  = s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_arLen[i]   = s_arlen[i*8 +: 8];
            w_arSize[i]  = s_arsize[i*3 +: 3];
            w_arBurst[i] = s_arburst[i*2 +: 2];
        end
    end

    rr_grant #(
        .NUM_REQ (NUM_REQ)
    ) u_rrGrant (
        .i_req      (s_arvalid),
        .i_rrPtr    (r_rrPtr),
        .o_grant    (w_grant),
        .o_grantIdx (w_winIdx),
        .o_anyReq   (w_anyReq)
    );

    assign w_take      = (r_state == IDLE) && w_anyReq;
    assign w_rreadySel = s_rready[r_grantIdx];
    assign w_beat      = (r_state == DATA) && m_axi_rvalid && w_rreadySel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // s_arready is gated by rst so a held request cannot leak a handshake while reset is asserted.
    always_comb begin
        w_nextState   = r_state;
        s_arready     = '0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        s_rvalid      = '0;
        case (r_state)
            IDLE: begin
                if (!rst) begin
                    s_arready = w_grant;
                end
                if (w_anyReq) begin
                    w_nextState = ADDR;
                end
            end
            ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    w_nextState = DATA;
                end
            end
            DATA: begin
                m_axi_rready = w_rreadySel;
                if (m_axi_rvalid) begin
                    s_rvalid = NUM_REQ'(1) << r_grantIdx;
                end
                if (w_beat && m_axi_rlast) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rrPtr     <= '0;
            r_grantIdx  <= '0;
            r_arId      <= '0;
            r_arAddr    <= '0;
            r_arLen     <= '0;
            r_arSize    <= '0;
            r_arBurst   <= '0;
            r_idErr     <= 1'b0;
            r_beatCount <= '0;
        end else begin
            if (w_take) begin
                r_grantIdx <= w_winIdx;
                r_arId     <= w_arId[w_winIdx];
                r_arAddr   <= w_arAddr[w_winIdx];
                r_arLen    <= w_arLen[w_winIdx];
                r_arSize   <= w_arSize[w_winIdx];
                r_arBurst  <= w_arBurst[w_winIdx];
            end
            if (w_beat) begin
                r_beatCount <= r_beatCount + 32'd1;
                if (m_axi_rid != r_arId) begin
                    r_idErr <= 1'b1;
                end
                // The pointer moves only when a burst retires, which is what bounds the wait to NUM_REQ bursts.
                if (m_axi_rlast) begin
                    r_rrPtr <= (r_grantIdx == IDX_W'(NUM_REQ-1)) ? '0 : r_grantIdx + 1'b1;
                end
            end
        end
    end

    assign m_axi_arid    = r_arId;
    assign m_axi_araddr  = r_arAddr;
    assign m_axi_arlen   = r_arLen;
    assign m_axi_arsize  = r_arSize;
    assign m_axi_arburst = r_arBurst;

    assign s_rid   = m_axi_rid;
    assign s_rdata = m_axi_rdata;
    assign s_rresp = m_axi_rresp;
    assign s_rlast = m_axi_rlast;

    assign grant_idx  = r_grantIdx;
    assign busy       = (r_state != IDLE);
    assign id_err     = r_idErr;
    assign beat_count = r_beatCount;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench: requester queues, a downstream slave model and a reference arbiter
// model feed a scoreboard of expected R beats, compared as the DUT delivers them.
`timescale 1ns/1ps
module tb_axi_rd_arbiter;

    import axi_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int AW   = 28;
    localparam int DW   = 64;
    localparam int IW   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ*IW-1:0] s_arid;
    logic [NREQ*AW-1:0] s_araddr;
    logic [NREQ*8-1:0]  s_arlen;
    logic [NREQ*3-1:0]  s_arsize;
    logic [NREQ*2-1:0]  s_arburst;
    logic [NREQ-1:0]    s_arvalid;
    logic [NREQ-1:0]    s_arready;
    logic [IW-1:0]      s_rid;
    logic [DW-1:0]      s_rdata;
    logic [1:0]         s_rresp;
    logic               s_rlast;
    logic [NREQ-1:0]    s_rvalid;
    logic [NREQ-1:0]    s_rready;
    logic [IW-1:0]      m_axi_arid;
    logic [AW-1:0]      m_axi_araddr;
    logic [7:0]         m_axi_arlen;
    logic [2:0]         m_axi_arsize;
    logic [1:0]         m_axi_arburst;
    logic               m_axi_arvalid;
    logic               m_axi_arready;
    logic [IW-1:0]      m_axi_rid;
    logic [DW-1:0]      m_axi_rdata;
    logic [1:0]         m_axi_rresp;
    logic               m_axi_rlast;
    logic               m_axi_rvalid;
    logic               m_axi_rready;
    logic [0:0]         grant_idx;
    logic               busy;
    logic               id_err;
    logic [31:0]        beat_count;

    always #5 clk = ~clk;

    axi_rd_arbiter #(
        .NUM_REQ    (NREQ),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_arid        (s_arid),
        .s_araddr      (s_araddr),
        .s_arlen       (s_arlen),
        .s_arsize      (s_arsize),
        .s_arburst     (s_arburst),
        .s_arvalid     (s_arvalid),
        .s_arready     (s_arready),
        .s_rid         (s_rid),
        .s_rdata       (s_rdata),
        .s_rresp       (s_rresp),
        .s_rlast       (s_rlast),
        .s_rvalid      (s_rvalid),
        .s_rready      (s_rready),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rid     (m_axi_rid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .grant_idx     (grant_idx),
        .busy          (busy),
        .id_err        (id_err),
        .beat_count    (beat_count)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } ar_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    int checks = 0;
    int errors = 0;

    ar_t   reqQ [NREQ][$];
    ar_t   arQ[$];
    beat_t expQ[$];
    int    grantLog[$];

    // Reference arbiter state
    arb_state_e    mdlState;
    int            mdlPtr;
    int            mdlGrant;
    int            mdlLen;
    int            mdlBeatNo;
    logic [IW-1:0] mdlCurId;
    logic          mdlIdErr;
    logic [31:0]   mdlBeats;

    // Downstream slave and stimulus knobs
    logic          slvActive;
    logic [AW-1:0] slvAddr;
    int            slvLen;
    int            slvBeat;
    logic [IW-1:0] slvId;
    int            arHold;
    logic          ridForce;
    logic [IW-1:0] ridForceVal;
    logic          stray;
    logic          rreadyMode;
    logic          tog;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [DW-1:0] mkData(input logic [AW-1:0] addr, input int beat);
        return {4'hA, addr, 32'(beat)};
    endfunction

    function automatic int pickWinner(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input int req, input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
        ar_t a;
        a.id   = id;
        a.addr = addr;
        a.len  = len;
        reqQ[req].push_back(a);
    endtask

    task automatic setInputs();
        for (int i = 0; i < NREQ; i++) begin
            s_arvalid[i]         = (reqQ[i].size() > 0);
            s_arid[i*IW +: IW]   = (reqQ[i].size() > 0) ? reqQ[i][0].id : '0;
            s_araddr[i*AW +: AW] = (reqQ[i].size() > 0) ? reqQ[i][0].addr : '0;
            s_arlen[i*8 +: 8]    = (reqQ[i].size() > 0) ? reqQ[i][0].len : '0;
            s_arsize[i*3 +: 3]   = 3'd3;
            s_arburst[i*2 +: 2]  = AXI_BURST_INCR;
        end
        m_axi_arready = (arHold == 0);
        m_axi_rvalid  = slvActive || stray;
        m_axi_rdata   = slvActive ? mkData(slvAddr, slvBeat) : 64'hDEAD_BEEF_0BAD_F00D;
        m_axi_rlast   = slvActive ? (slvBeat == slvLen) : 1'b1;
        m_axi_rid     = ridForce ? ridForceVal : slvId;
        m_axi_rresp   = RESP_OKAY;
        s_rready      = '1;
        if (rreadyMode) s_rready[1] = tog;
        tog = ~tog;
    endtask

    task automatic stepCycle();
        int            win;
        logic          mdlUp, mdlDn, mdlBeat, rr, sArHs, sRHs, sArvSeen;
        logic [NREQ-1:0] oh, hsVec;
        logic [IW-1:0] ridSeen, expRid;
        logic [AW-1:0] araddrSeen;
        logic [7:0]    arlenSeen;
        logic [IW-1:0] aridSeen;
        ar_t           upAr, a;
        beat_t         b;

        setInputs();
        #2;
        win   = pickWinner(s_arvalid, mdlPtr);
        mdlUp = (mdlState == IDLE) && (win >= 0);
        oh    = '0;
        if (mdlUp) begin
            oh[win] = 1'b1;
            upAr    = reqQ[win][0];
        end
        checkOutput("s_arready", 64'(s_arready), 64'(oh));
        checkOutput("m_arvalid", 64'(m_axi_arvalid), 64'(mdlState == ADDR));
        if (mdlState == ADDR && arQ.size() > 0) begin
            checkOutput("m_araddr", 64'(m_axi_araddr), 64'(arQ[0].addr));
            checkOutput("m_arlen", 64'(m_axi_arlen), 64'(arQ[0].len));
            checkOutput("m_arid", 64'(m_axi_arid), 64'(arQ[0].id));
            checkOutput("m_arsize", 64'(m_axi_arsize), 64'd3);
            checkOutput("m_arburst", 64'(m_axi_arburst), 64'(AXI_BURST_INCR));
        end
        rr = (mdlState == DATA) ? s_rready[mdlGrant] : 1'b0;
        checkOutput("m_rready", 64'(m_axi_rready), 64'(rr));
        oh = '0;
        if (mdlState == DATA && m_axi_rvalid) oh[mdlGrant] = 1'b1;
        checkOutput("s_rvalid", 64'(s_rvalid), 64'(oh));
        checkOutput("grant_idx", 64'(grant_idx), 64'(mdlGrant));
        checkOutput("busy", 64'(busy), 64'(mdlState != IDLE));
        checkOutput("id_err", 64'(id_err), 64'(mdlIdErr));
        checkOutput("beat_count", 64'(beat_count), 64'(mdlBeats));

        mdlBeat = (mdlState == DATA) && m_axi_rvalid && rr;
        if (mdlBeat) begin
            if (expQ.size() == 0) begin
                checkOutput("beat_unexpected", 64'(expQ.size()), 64'd1);
            end else begin
                b      = expQ.pop_front();
                expRid = ridForce ? ridForceVal : mdlCurId;
                checkOutput("s_rdata", s_rdata, b.data);
                checkOutput("s_rlast", 64'(s_rlast), 64'(b.last));
                checkOutput("s_rid", 64'(s_rid), 64'(expRid));
                checkOutput("s_rresp", 64'(s_rresp), 64'(RESP_OKAY));
            end
        end
        mdlDn      = (mdlState == ADDR) && m_axi_arready;
        hsVec      = s_arvalid & s_arready;
        sArHs      = m_axi_arvalid && m_axi_arready;
        sRHs       = m_axi_rvalid && m_axi_rready && slvActive;
        sArvSeen   = m_axi_arvalid;
        ridSeen    = m_axi_rid;
        araddrSeen = m_axi_araddr;
        arlenSeen  = m_axi_arlen;
        aridSeen   = m_axi_arid;

        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < NREQ; i++) begin
            if (hsVec[i] && reqQ[i].size() > 0) void'(reqQ[i].pop_front());
        end
        if (mdlUp) begin
            arQ.push_back(upAr);
            grantLog.push_back(win);
            mdlGrant = win;
            mdlCurId = upAr.id;
            mdlState = ADDR;
        end else if (mdlDn) begin
            a         = arQ.pop_front();
            mdlLen    = int'(a.len);
            mdlBeatNo = 0;
            for (int k = 0; k <= mdlLen; k++) begin
                b.data = mkData(a.addr, k);
                b.last = (k == mdlLen);
                expQ.push_back(b);
            end
            mdlState = DATA;
        end else if (mdlBeat) begin
            mdlBeats++;
            if (ridSeen != mdlCurId) mdlIdErr = 1'b1;
            if (mdlBeatNo == mdlLen) begin
                mdlPtr   = (mdlGrant + 1) % NREQ;
                mdlState = IDLE;
            end else begin
                mdlBeatNo++;
            end
        end
        if (sRHs) begin
            if (slvBeat == slvLen) slvActive = 1'b0;
            else slvBeat++;
        end
        if (sArHs) begin
            slvActive = 1'b1;
            slvAddr   = araddrSeen;
            slvLen    = int'(arlenSeen);
            slvId     = aridSeen;
            slvBeat   = 0;
        end
        if (sArvSeen && arHold > 0) arHold--;
    endtask

    task automatic runUntilIdle(input int budget);
        int n = 0;
        stepCycle();
        n++;
        while (!(mdlState == IDLE && reqQ[0].size() == 0 && reqQ[1].size() == 0) && n < budget) begin
            stepCycle();
            n++;
        end
        checkOutput("idle_within_budget", 64'(mdlState == IDLE && reqQ[0].size() == 0 && reqQ[1].size() == 0), 64'd1);
    endtask

    // Asserts rst wherever the bench currently is in the cycle and checks the asynchronous clear.
    task automatic applyReset();
        rst = 1'b1;
        #1;
        checkOutput("rst_s_arready", 64'(s_arready), 64'd0);
        checkOutput("rst_s_rvalid", 64'(s_rvalid), 64'd0);
        checkOutput("rst_m_arvalid", 64'(m_axi_arvalid), 64'd0);
        checkOutput("rst_m_rready", 64'(m_axi_rready), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_grant_idx", 64'(grant_idx), 64'd0);
        checkOutput("rst_id_err", 64'(id_err), 64'd0);
        checkOutput("rst_beat_count", 64'(beat_count), 64'd0);
        checkOutput("rst_m_araddr", 64'(m_axi_araddr), 64'd0);
        for (int i = 0; i < NREQ; i++) reqQ[i].delete();
        arQ.delete();
        expQ.delete();
        grantLog.delete();
        mdlState  = IDLE;
        mdlPtr    = 0;
        mdlGrant  = 0;
        mdlLen    = 0;
        mdlBeatNo = 0;
        mdlCurId  = '0;
        mdlIdErr  = 1'b0;
        mdlBeats  = '0;
        slvActive = 1'b0;
        slvAddr   = '0;
        slvLen    = 0;
        slvBeat   = 0;
        slvId     = '0;
        arHold    = 0;
        ridForce  = 1'b0;
        ridForceVal = '0;
        stray     = 1'b0;
        rreadyMode = 1'b0;
        tog       = 1'b0;
        setInputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int startBeats;
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) reqQ[i].delete();
        slvActive = 1'b0;
        slvAddr   = '0;
        slvLen    = 0;
        slvBeat   = 0;
        slvId     = '0;
        arHold    = 0;
        ridForce  = 1'b0;
        ridForceVal = '0;
        stray     = 1'b0;
        rreadyMode = 1'b0;
        tog       = 1'b0;
        setInputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        applyReset();
        repeat (2) stepCycle();

        $display("[TB] single requester burst");
        applyStimulus(0, 4'd2, 28'h100, 8'd3);
        runUntilIdle(100);
        checkOutput("single_beat_count", 64'(beat_count), 64'd4);
        checkOutput("single_busy_after", 64'(busy), 64'd0);

        $display("[TB] contention");
        applyReset();
        applyStimulus(0, 4'd1, 28'h200, 8'd1);
        applyStimulus(1, 4'd5, 28'h300, 8'd1);
        applyStimulus(0, 4'd1, 28'h240, 8'd1);
        applyStimulus(1, 4'd5, 28'h340, 8'd1);
        runUntilIdle(200);
        checkOutput("contention_bursts", 64'(grantLog.size()), 64'd4);
        if (grantLog.size() == 4) begin
            checkOutput("grant_order_0", 64'(grantLog[0]), 64'd0);
            checkOutput("grant_order_1", 64'(grantLog[1]), 64'd1);
            checkOutput("grant_order_2", 64'(grantLog[2]), 64'd0);
            checkOutput("grant_order_3", 64'(grantLog[3]), 64'd1);
        end

        $display("[TB] backpressure");
        startBeats = int'(mdlBeats);
        rreadyMode = 1'b1;
        applyStimulus(1, 4'd7, 28'h400, 8'd7);
        runUntilIdle(200);
        rreadyMode = 1'b0;
        checkOutput("bp_beat_count", 64'(beat_count), 64'(startBeats + 8));

        $display("[TB] slow downstream AR");
        arHold = 5;
        applyStimulus(0, 4'd3, 28'h500, 8'd0);
        applyStimulus(1, 4'd4, 28'h600, 8'd0);
        runUntilIdle(200);

        $display("[TB] rid mismatch");
        ridForce    = 1'b1;
        ridForceVal = 4'd3;
        applyStimulus(0, 4'd2, 28'h700, 8'd1);
        runUntilIdle(100);
        ridForce = 1'b0;
        checkOutput("id_err_set", 64'(id_err), 64'd1);
        applyStimulus(1, 4'd6, 28'h800, 8'd2);
        runUntilIdle(100);
        checkOutput("id_err_sticky", 64'(id_err), 64'd1);

        $display("[TB] stray R beat while idle");
        startBeats = int'(mdlBeats);
        stray = 1'b1;
        repeat (3) stepCycle();
        stray = 1'b0;
        checkOutput("stray_not_counted", 64'(beat_count), 64'(startBeats));

        $display("[TB] reset mid-burst");
        applyStimulus(1, 4'd4, 28'h900, 8'd3);
        begin
            int n = 0;
            while (!(mdlState == DATA && mdlBeatNo == 2) && n < 100) begin
                stepCycle();
                n++;
            end
            checkOutput("reached_beat_2", 64'(mdlState == DATA && mdlBeatNo == 2), 64'd1);
        end
        setInputs();
        #2;
        applyReset();
        applyStimulus(1, 4'd1, 28'hA00, 8'd0);
        applyStimulus(0, 4'd2, 28'hB00, 8'd0);
        runUntilIdle(100);
        checkOutput("post_rst_bursts", 64'(grantLog.size()), 64'd2);
        if (grantLog.size() > 0) begin
            checkOutput("post_rst_first_grant", 64'(grantLog[0]), 64'd0);
        end
        repeat (2) stepCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
